// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, status flag positions and
// format helpers for the parametrised FP datapath.
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    localparam int unsigned FLAG_W         = 4;
    localparam int unsigned FLAG_INEXACT   = 0;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_INVALID   = 3;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
    function automatic logic [63:0] qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 32'd1));
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// Normalise/round/pack for a full-width mantissa product (combinational).
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise truncation toward zero.
module fp_mul_round
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     sign,
    input  logic [2*MAN_W+1:0]       prod,
    input  logic [EXP_W+1:0]         esum,
    output logic [EXP_W+MAN_W:0]     p,
    output logic [FLAG_W-1:0]        flags
);

    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic [PW-1:0]    norm;
    logic [EW-1:0]    exp_n;
    logic [EW-1:0]    exp_r;
    logic [MAN_W-1:0] man;
    logic [MAN_W:0]   man_r;
    logic             guard;
    logic             sticky;
    logic             round_up;

    always_comb begin
        // Product lies in [1,4); align so the leading one sits at the MSB.
        norm   = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
        exp_n  = prod[PW-1] ? esum + EW'(1) : esum;
        man    = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
`ifdef FP_MUL_RNE_EN
        round_up = guard & (sticky | man[0]);
`else
        round_up = 1'b0;
`endif
        // A carry out of the fraction leaves it all-zero: 1.11..1 + ulp = 10.0.
        man_r = {1'b0, man} + (MAN_W + 1)'(round_up);
        exp_r = exp_n + EW'(man_r[MAN_W]);

        flags               = '0;
        flags[FLAG_INEXACT] = guard | sticky;
        p                   = {sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};

        if (!exp_r[EW-1] && (exp_r >= EXP_MAX)) begin
            p                     = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags[FLAG_OVERFLOW]  = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            p                     = {sign, {(EXP_W + MAN_W){1'b0}}};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready, special operands,
// status flags and a sideband tag. Rounding mode chosen by FP_MUL_RNE_EN.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_p,
    output logic [TAG_W-1:0]         out_tag,
    output logic [FLAG_W-1:0]        out_flags
);

    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam int unsigned EW = EXP_W + 2;
    localparam logic [W-1:0]  QNAN   = W'(qnan(EXP_W, MAN_W));
    localparam logic [EW-1:0] BIAS_E = EW'(bias(EXP_W));

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0) return FP_ZERO;
        if (e == '1) return (m == '0) ? FP_INF : FP_NAN;
        return FP_NORM;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: unpack and classify
    logic             s1_valid;
    logic             s1_sign;
    fp_class_e        s1_class_a;
    fp_class_e        s1_class_b;
    logic [EW-1:0]    s1_esum;
    logic [MAN_W-1:0] s1_man_a;
    logic [MAN_W-1:0] s1_man_b;
    logic [TAG_W-1:0] s1_tag;

    logic [EW-1:0]    esum_d;
    assign esum_d = {2'b00, in_a[W-2:MAN_W]} + {2'b00, in_b[W-2:MAN_W]} - BIAS_E;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_class_a <= FP_ZERO;
            s1_class_b <= FP_ZERO;
            s1_esum    <= '0;
            s1_man_a   <= '0;
            s1_man_b   <= '0;
            s1_tag     <= '0;
        end else if (advance) begin
            s1_valid   <= in_valid;
            s1_sign    <= in_a[W-1] ^ in_b[W-1];
            s1_class_a <= classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
            s1_class_b <= classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
            s1_esum    <= esum_d;
            s1_man_a   <= in_a[MAN_W-1:0];
            s1_man_b   <= in_b[MAN_W-1:0];
            s1_tag     <= in_tag;
        end
    end

    // S2: mantissa product and special-operand decode
    logic              s2_valid;
    logic              s2_sign;
    logic              s2_special;
    logic [W-1:0]      s2_special_p;
    logic [FLAG_W-1:0] s2_special_flags;
    logic [EW-1:0]     s2_esum;
    logic [PW-1:0]     s2_prod;
    logic [TAG_W-1:0]  s2_tag;

    logic              special_d;
    logic [W-1:0]      special_p_d;
    logic [FLAG_W-1:0] special_flags_d;
    logic [PW-1:0]     op_a;
    logic [PW-1:0]     op_b;
    logic [PW-1:0]     prod_d;

    assign op_a   = {{(MAN_W + 1){1'b0}}, 1'b1, s1_man_a};
    assign op_b   = {{(MAN_W + 1){1'b0}}, 1'b1, s1_man_b};
    assign prod_d = op_a * op_b;

    always_comb begin
        special_d       = 1'b1;
        special_p_d     = '0;
        special_flags_d = '0;
        if (s1_class_a == FP_NAN || s1_class_b == FP_NAN) begin
            special_p_d = QNAN;
        end else if ((s1_class_a == FP_INF && s1_class_b == FP_ZERO) ||
                     (s1_class_a == FP_ZERO && s1_class_b == FP_INF)) begin
            special_p_d                   = QNAN;
            special_flags_d[FLAG_INVALID] = 1'b1;
        end else if (s1_class_a == FP_INF || s1_class_b == FP_INF) begin
            special_p_d = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_class_a == FP_ZERO || s1_class_b == FP_ZERO) begin
            special_p_d = {s1_sign, {(W - 1){1'b0}}};
        end else begin
            special_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid         <= 1'b0;
            s2_sign          <= 1'b0;
            s2_special       <= 1'b0;
            s2_special_p     <= '0;
            s2_special_flags <= '0;
            s2_esum          <= '0;
            s2_prod          <= '0;
            s2_tag           <= '0;
        end else if (advance) begin
            s2_valid         <= s1_valid;
            s2_sign          <= s1_sign;
            s2_special       <= special_d;
            s2_special_p     <= special_p_d;
            s2_special_flags <= special_flags_d;
            s2_esum          <= s1_esum;
            s2_prod          <= prod_d;
            s2_tag           <= s1_tag;
        end
    end

    // S3: normalise/round/pack, output register
    logic [W-1:0]      round_p;
    logic [FLAG_W-1:0] round_flags;

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign  (s2_sign),
        .prod  (s2_prod),
        .esum  (s2_esum),
        .p     (round_p),
        .flags (round_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_p     <= s2_special ? s2_special_p : round_p;
            out_tag   <= s2_tag;
            out_flags <= s2_special ? s2_special_flags : round_flags;
        end
    end

endmodule
